// File: rtl/imply_pkg.sv
// Shared definitions for the sequential LUT implication block: ternary pin
// encoding, pin-field helpers and the controller state encoding.
package imply_pkg;

    // Each LUT pin is a two-bit ternary field.
    localparam int unsigned PIN_W = 2;

    localparam logic [PIN_W-1:0] PIN_ZERO    = 2'b00;
    localparam logic [PIN_W-1:0] PIN_ONE     = 2'b10;
    localparam logic [PIN_W-1:0] PIN_UNKNOWN = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    // Bit 0 clear means the pin carries a value; 01 therefore reads as UNKNOWN.
    function automatic logic pin_known(input logic [PIN_W-1:0] pin);
        return ~pin[0];
    endfunction

    // Value of a known pin lives in the upper bit.
    function automatic logic pin_value(input logic [PIN_W-1:0] pin);
        return pin[1];
    endfunction

endpackage

// File: rtl/imply_chunk.sv
// Combinational evaluation of one truth-table slice: finds which addresses in
// the slice agree with the current pin assignment and which values each pin
// takes across those addresses.
module imply_chunk
    import imply_pkg::*;
#(
    parameter int unsigned LUT_SIZE   = 8,
    parameter int unsigned CHUNK_BITS = 32
) (
    input  logic [PIN_W*(LUT_SIZE+1)-1:0] pins,
    input  logic [CHUNK_BITS-1:0]         tt_slice,
    input  logic [LUT_SIZE-1:0]           base,
    output logic                          any_compat,
    output logic [LUT_SIZE:0]             seen0,
    output logic [LUT_SIZE:0]             seen1
);

    logic [LUT_SIZE-1:0] addr;
    logic                compat;

    // Walk every address of the slice; index LUT_SIZE of seen0/seen1 is the output pin.
    always_comb begin
        any_compat = 1'b0;
        seen0      = '0;
        seen1      = '0;
        addr       = '0;
        compat     = 1'b0;
        for (int j = 0; j < CHUNK_BITS; j++) begin
            addr   = base + LUT_SIZE'(j);
            compat = 1'b1;
            for (int i = 0; i < LUT_SIZE; i++) begin
                if (pin_known(pins[PIN_W*i +: PIN_W]) &&
                    (pin_value(pins[PIN_W*i +: PIN_W]) != addr[i])) begin
                    compat = 1'b0;
                end
            end
            if (pin_known(pins[PIN_W*LUT_SIZE +: PIN_W]) &&
                (pin_value(pins[PIN_W*LUT_SIZE +: PIN_W]) != tt_slice[j])) begin
                compat = 1'b0;
            end
            if (compat) begin
                any_compat = 1'b1;
                for (int i = 0; i < LUT_SIZE; i++) begin
                    if (addr[i]) seen1[i] = 1'b1;
                    else         seen0[i] = 1'b1;
                end
                if (tt_slice[j]) seen1[LUT_SIZE] = 1'b1;
                else             seen0[LUT_SIZE] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/imply_seq.sv
// Sequential LUT implication: accepts one job, scans the truth table a chunk
// per cycle, then presents implied pins with conflict/changed flags until the
// consumer takes them.
module imply_seq
    import imply_pkg::*;
#(
    parameter int unsigned LUT_SIZE   = 8,
    parameter int unsigned CHUNK_BITS = 32,
    parameter int unsigned TAG_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PIN_W*(LUT_SIZE+1)-1:0] in_pins,
    input  logic [(2**LUT_SIZE)-1:0]      in_tt,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PIN_W*(LUT_SIZE+1)-1:0] out_pins,
    output logic                          out_conflict,
    output logic                          out_changed,
    output logic [TAG_W-1:0]              out_tag
);

    localparam int unsigned PINS_W      = PIN_W * (LUT_SIZE + 1);
    localparam int unsigned TT_W        = 2 ** LUT_SIZE;
    localparam int unsigned NUM_CHUNKS  = TT_W / CHUNK_BITS;
    localparam int unsigned CNT_W       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int unsigned CHUNK_SHIFT = $clog2(CHUNK_BITS);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    chunk_q;
    logic [PINS_W-1:0]   pins_q;
    logic [TT_W-1:0]     tt_q;
    logic [TAG_W-1:0]    tag_q;
    logic                any_q;
    logic [LUT_SIZE:0]   seen0_q, seen1_q;
    logic [PINS_W-1:0]   out_pins_q;
    logic                out_conflict_q, out_changed_q;
    logic [TAG_W-1:0]    out_tag_q;

    logic                accept, last_chunk;
    logic [LUT_SIZE-1:0] chunk_base;
    logic [CHUNK_BITS-1:0] tt_slice;
    logic                c_any;
    logic [LUT_SIZE:0]   c_seen0, c_seen1;
    logic                fin_any;
    logic [LUT_SIZE:0]   fin_seen0, fin_seen1;
    logic [PINS_W-1:0]   res_pins;
    logic                res_changed;
    logic [PIN_W-1:0]    res_field;

    assign accept     = (state_q == StIdle) && in_valid;
    assign last_chunk = (state_q == StScan) && (chunk_q == CNT_W'(NUM_CHUNKS - 1));
    assign chunk_base = LUT_SIZE'(chunk_q) << CHUNK_SHIFT;
    assign tt_slice   = tt_q[chunk_base +: CHUNK_BITS];

    imply_chunk #(
        .LUT_SIZE   (LUT_SIZE),
        .CHUNK_BITS (CHUNK_BITS)
    ) u_chunk (
        .pins       (pins_q),
        .tt_slice   (tt_slice),
        .base       (chunk_base),
        .any_compat (c_any),
        .seen0      (c_seen0),
        .seen1      (c_seen1)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic: idle -> scan on accept, scan -> done after last chunk, done -> idle on take.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)   state_d = StScan;
            StScan:  if (last_chunk) state_d = StDone;
            StDone:  if (out_ready)  state_d = StIdle;
            default:                 state_d = StIdle;
        endcase
    end

    // Result formatting; folds in the current chunk so the last chunk needs no extra cycle.
    always_comb begin
        fin_any     = any_q | c_any;
        fin_seen0   = seen0_q | c_seen0;
        fin_seen1   = seen1_q | c_seen1;
        res_pins    = pins_q;
        res_changed = 1'b0;
        res_field   = '0;
        if (fin_any) begin
            for (int p = 0; p <= LUT_SIZE; p++) begin
                res_field = pins_q[PIN_W*p +: PIN_W];
                if (!pin_known(res_field)) begin
                    if (fin_seen1[p] && !fin_seen0[p]) begin
                        res_pins[PIN_W*p +: PIN_W] = PIN_ONE;
                        res_changed = 1'b1;
                    end else if (fin_seen0[p] && !fin_seen1[p]) begin
                        res_pins[PIN_W*p +: PIN_W] = PIN_ZERO;
                        res_changed = 1'b1;
                    end else begin
                        res_pins[PIN_W*p +: PIN_W] = PIN_UNKNOWN;
                    end
                end
            end
        end
    end

    // Job latches, chunk counter, accumulators and registered results.
    always_ff @(posedge clk) begin
        if (reset) begin
            chunk_q        <= '0;
            pins_q         <= '1;
            tt_q           <= '0;
            tag_q          <= '0;
            any_q          <= 1'b0;
            seen0_q        <= '0;
            seen1_q        <= '0;
            out_pins_q     <= '1;
            out_conflict_q <= 1'b0;
            out_changed_q  <= 1'b0;
            out_tag_q      <= '0;
        end else if (accept) begin
            pins_q  <= in_pins;
            tt_q    <= in_tt;
            tag_q   <= in_tag;
            chunk_q <= '0;
            any_q   <= 1'b0;
            seen0_q <= '0;
            seen1_q <= '0;
        end else if (state_q == StScan) begin
            any_q   <= fin_any;
            seen0_q <= fin_seen0;
            seen1_q <= fin_seen1;
            if (last_chunk) begin
                out_pins_q     <= res_pins;
                out_conflict_q <= ~fin_any;
                out_changed_q  <= res_changed;
                out_tag_q      <= tag_q;
            end else begin
                chunk_q <= chunk_q + CNT_W'(1);
            end
        end
    end

    assign in_ready     = (state_q == StIdle);
    assign out_valid    = (state_q == StDone);
    assign out_pins     = out_pins_q;
    assign out_conflict = out_conflict_q;
    assign out_changed  = out_changed_q;
    assign out_tag      = out_tag_q;

endmodule

// File: tb/tb_imply_seq.sv
// Bench for imply_seq: one instance scanning 32 addresses per cycle, one
// scanning the whole table in a single cycle, checked against a truth-table
// enumeration model.
module tb_imply_seq;

    localparam int LUT = 8;
    localparam int PW  = 2 * LUT + 2;
    localparam int TTW = 256;

    logic clk = 1'b0;
    logic reset;

    logic          in_valid0, in_ready0, out_valid0, out_ready0, out_conflict0, out_changed0;
    logic [PW-1:0] in_pins0, out_pins0;
    logic [TTW-1:0] in_tt0;
    logic [7:0]    in_tag0, out_tag0;

    logic          in_valid1, in_ready1, out_valid1, out_ready1, out_conflict1, out_changed1;
    logic [PW-1:0] in_pins1, out_pins1;
    logic [TTW-1:0] in_tt1;
    logic [7:0]    in_tag1, out_tag1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imply_seq #(.LUT_SIZE(8), .CHUNK_BITS(32), .TAG_W(8)) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_pins(in_pins0), .in_tt(in_tt0),
        .in_tag(in_tag0), .out_valid(out_valid0), .out_ready(out_ready0),
        .out_pins(out_pins0), .out_conflict(out_conflict0), .out_changed(out_changed0),
        .out_tag(out_tag0)
    );

    imply_seq #(.LUT_SIZE(8), .CHUNK_BITS(256), .TAG_W(8)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_pins(in_pins1), .in_tt(in_tt1),
        .in_tag(in_tag1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_pins(out_pins1), .out_conflict(out_conflict1), .out_changed(out_changed1),
        .out_tag(out_tag1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [PW-1:0] p,
                         input logic [TTW-1:0] t, input logic [7:0] g);
        if (sel == 0) begin
            in_valid0 = v; in_pins0 = p; in_tt0 = t; in_tag0 = g;
        end else begin
            in_valid1 = v; in_pins1 = p; in_tt1 = t; in_tag1 = g;
        end
    endtask

    task automatic set_ready(input int sel, input logic r);
        if (sel == 0) out_ready0 = r;
        else          out_ready1 = r;
    endtask

    task automatic sample(input int sel, output logic ir, output logic ov,
                          output logic [PW-1:0] op, output logic oc, output logic och,
                          output logic [7:0] ot);
        if (sel == 0) begin
            ir = in_ready0; ov = out_valid0; op = out_pins0;
            oc = out_conflict0; och = out_changed0; ot = out_tag0;
        end else begin
            ir = in_ready1; ov = out_valid1; op = out_pins1;
            oc = out_conflict1; och = out_changed1; ot = out_tag1;
        end
    endtask

    // Enumerate every input address; a pin is forced when all consistent rows agree on it.
    task automatic model(input logic [PW-1:0] p, input logic [TTW-1:0] t,
                         output logic [PW-1:0] ep, output logic ec, output logic ech);
        int val[9];
        int cnt0[9];
        int cnt1[9];
        int rows;
        int bitv;
        rows = 0;
        for (int k = 0; k < 9; k++) begin
            val[k]  = (p[2*k] == 1'b0) ? int'(p[2*k+1]) : -1;
            cnt0[k] = 0;
            cnt1[k] = 0;
        end
        for (int a = 0; a < TTW; a++) begin
            bit ok;
            ok = 1'b1;
            for (int k = 0; k < 8; k++)
                if (val[k] >= 0 && val[k] != ((a >> k) & 1)) ok = 1'b0;
            if (val[8] >= 0 && val[8] != int'(t[a])) ok = 1'b0;
            if (ok) begin
                rows++;
                for (int k = 0; k < 9; k++) begin
                    bitv = (k < 8) ? ((a >> k) & 1) : int'(t[a]);
                    if (bitv == 1) cnt1[k]++;
                    else           cnt0[k]++;
                end
            end
        end
        ep  = p;
        ec  = (rows == 0);
        ech = 1'b0;
        if (rows != 0) begin
            for (int k = 0; k < 9; k++) begin
                if (val[k] < 0) begin
                    if (cnt0[k] == 0)      begin ep[2*k +: 2] = 2'b10; ech = 1'b1; end
                    else if (cnt1[k] == 0) begin ep[2*k +: 2] = 2'b00; ech = 1'b1; end
                    else                         ep[2*k +: 2] = 2'b11;
                end
            end
        end
    endtask

    function automatic logic [TTW-1:0] tt_of(input int kind);
        logic [TTW-1:0] t;
        for (int a = 0; a < TTW; a++) begin
            case (kind)
                1:       t[a] = ((a & 1) != 0) && ((a & 2) != 0);
                2:       t[a] = (a & 1) != 0;
                default: t[a] = 1'b0;
            endcase
        end
        return t;
    endfunction

    task automatic check_reset_state(input int sel, input string name);
        logic ir, ov, oc, och;
        logic [PW-1:0] op;
        logic [7:0] ot;
        sample(sel, ir, ov, op, oc, och, ot);
        check({name, ".in_ready"}, 64'(ir), 64'd1);
        check({name, ".out_valid"}, 64'(ov), 64'd0);
        check({name, ".out_pins"}, 64'(op), 64'h3ffff);
        check({name, ".out_conflict"}, 64'(oc), 64'd0);
        check({name, ".out_changed"}, 64'(och), 64'd0);
        check({name, ".out_tag"}, 64'(ot), 64'd0);
    endtask

    task automatic run_job(input int sel, input logic [PW-1:0] p, input logic [TTW-1:0] t,
                           input logic [7:0] g, input int hold, input string name);
        logic ir, ov, oc, och, ec, ech;
        logic [PW-1:0] op, ep;
        logic [7:0] ot;
        int lat;
        sample(sel, ir, ov, op, oc, och, ot);
        check({name, ".ready_before"}, 64'(ir), 64'd1);
        drive(sel, 1'b1, p, t, g);
        @(posedge clk); #1;
        // Junk on the inputs after accept must not leak into the job.
        drive(sel, 1'b0, ~p, ~t, ~g);
        lat = 0;
        sample(sel, ir, ov, op, oc, och, ot);
        while (!ov && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            sample(sel, ir, ov, op, oc, och, ot);
        end
        check({name, ".latency"}, 64'(lat), (sel == 0) ? 64'd8 : 64'd1);
        model(p, t, ep, ec, ech);
        check({name, ".out_pins"}, 64'(op), 64'(ep));
        check({name, ".out_conflict"}, 64'(oc), 64'(ec));
        check({name, ".out_changed"}, 64'(och), 64'(ech));
        check({name, ".out_tag"}, 64'(ot), 64'(g));
        check({name, ".ready_busy"}, 64'(ir), 64'd0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            sample(sel, ir, ov, op, oc, och, ot);
            check({name, ".hold_valid"}, 64'(ov), 64'd1);
            check({name, ".hold_pins"}, 64'({op, oc, och, ot}), 64'({ep, ec, ech, g}));
            check({name, ".hold_ready"}, 64'(ir), 64'd0);
        end
        set_ready(sel, 1'b1);
        @(posedge clk); #1;
        set_ready(sel, 1'b0);
        sample(sel, ir, ov, op, oc, och, ot);
        check({name, ".valid_after"}, 64'(ov), 64'd0);
        check({name, ".ready_after"}, 64'(ir), 64'd1);
    endtask

    initial begin
        logic [PW-1:0] p;
        logic [TTW-1:0] t;
        logic ov_chk;

        reset = 1'b1;
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        out_ready0 = 1'b0;
        out_ready1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state(0, "rst0");
        check_reset_state(1, "rst1");
        reset = 1'b0;

        // Constant-zero table forces the output pin to ZERO.
        run_job(0, '1, tt_of(0), 8'h5a, 0, "zero_tt");

        // AND with output ONE forces both inputs ONE.
        p = '1; p[17:16] = 2'b10;
        run_job(0, p, tt_of(1), 8'h11, 0, "and_out1");

        // AND, pin0 ONE, output ZERO forces pin1 ZERO.
        p = '1; p[1:0] = 2'b10; p[17:16] = 2'b00;
        run_job(0, p, tt_of(1), 8'h22, 0, "and_p1zero");

        // AND with both inputs ONE and output ZERO is a conflict.
        p = '1; p[1:0] = 2'b10; p[3:2] = 2'b10; p[17:16] = 2'b00;
        run_job(0, p, tt_of(1), 8'h33, 0, "and_conflict");

        // Backpressure for five cycles, then an immediate second job.
        p = '1; p[17:16] = 2'b10;
        run_job(0, p, tt_of(1), 8'h44, 5, "hold");
        p = '1; p[3:2] = 2'b01; p[17:16] = 2'b00;
        run_job(0, p, tt_of(2), 8'h45, 0, "b2b");

        // Reset while chunk 3 is being scanned.
        drive(0, 1'b1, '1, tt_of(1), 8'h99);
        @(posedge clk); #1;
        drive(0, 1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_state(0, "rst_scan");
        p = '1; p[1:0] = 2'b10;
        run_job(0, p, tt_of(2), 8'h77, 0, "proj_after_rst");

        // Single-chunk instance: same scenarios with one-cycle scan.
        run_job(1, '1, tt_of(0), 8'ha5, 0, "w_zero_tt");
        p = '1; p[1:0] = 2'b10; p[17:16] = 2'b00;
        run_job(1, p, tt_of(1), 8'hb6, 3, "w_and_p1zero");
        p = '1; p[1:0] = 2'b10;
        run_job(1, p, tt_of(2), 8'hc7, 0, "w_proj");

        // Reset while a result is pending in DONE.
        drive(1, 1'b1, '1, tt_of(0), 8'hee);
        @(posedge clk); #1;
        drive(1, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
        ov_chk = out_valid1;
        check("w_done_pending", 64'(ov_chk), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_state(1, "rst_done");

        // Random jobs, mostly-unknown pins so implications are common.
        for (int n = 0; n < 16; n++) begin
            for (int k = 0; k < 9; k++) begin
                int r;
                r = $urandom_range(0, 5);
                case (r)
                    0:       p[2*k +: 2] = 2'b00;
                    1:       p[2*k +: 2] = 2'b10;
                    2:       p[2*k +: 2] = 2'b01;
                    default: p[2*k +: 2] = 2'b11;
                endcase
            end
            for (int w = 0; w < 8; w++) t[32*w +: 32] = $urandom;
            if (n % 4 == 0) t = t & (t >> 1) & (t >> 3);
            run_job(n % 2, p, t, 8'($urandom), n % 3, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
